ifmap_window_reader: RTL and testbench

// Consumer side of the IFMap circular buffer. The write-side controller fills rows and reports row availability.

---
 rtl/ifmap_window_reader_pkg.sv | 27 ++
 rtl/ifmap_window_reader_circ_addr_gen.sv | 26 ++
 rtl/ifmap_window_reader.sv | 172 +++++++++++++++++
 tb/tb_ifmap_window_reader.sv | 391 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifmap_window_reader_pkg.sv
// ifmap_rd_pkg: shared definitions for the IFMap circular-buffer read and
// write controllers.
//   - Default widths for buffer pointers, filter size and stride.
//   - FSM state codes. The legacy constants are kept so existing code that
//     compares raw 3-bit codes still works. state_t is built from them.
package ifmap_rd_pkg;

  localparam int ADDR_W_DEF    = 8;
  localparam int BUF_DEPTH_DEF = 16;
  localparam int FS_W_DEF      = 5;
  localparam int STRIDE_W_DEF  = 3;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_WAIT_ROW = 3'd1;
  localparam logic [2:0] ST_LATCH    = 3'd2;
  localparam logic [2:0] ST_READ     = 3'd3;
  localparam logic [2:0] ST_ROW_DONE = 3'd4;

  typedef enum logic [2:0] {
    IDLE     = ST_IDLE,
    WAIT_ROW = ST_WAIT_ROW,
    LATCH    = ST_LATCH,
    READ     = ST_READ,
    ROW_DONE = ST_ROW_DONE
  } state_t;

endpackage

// File: rtl/ifmap_window_reader_circ_addr_gen.sv
// circ_addr_gen: combinational (base + offset) modulo BUF_DEPTH for the
// IFMap circular buffer. The write-side controller uses it as well.
//   base   in  ADDR_W  buffer address of element 0 of a row (< BUF_DEPTH)
//   offset in  ADDR_W  element offset within the row (< BUF_DEPTH)
//   addr   out ADDR_W  wrapped buffer address
module circ_addr_gen #(
  parameter int ADDR_W    = 8,
  parameter int BUF_DEPTH = 16
) (
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] offset,
  output logic [ADDR_W-1:0] addr
);

  localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(BUF_DEPTH);

  logic [ADDR_W:0] sum;
  logic [ADDR_W:0] wrapped;

  // Both operands are below BUF_DEPTH, so a single subtract always lands
  // the sum back inside the buffer.
  assign sum     = {1'b0, base} + {1'b0, offset};
  assign wrapped = (sum >= DEPTH) ? (sum - DEPTH) : sum;
  assign addr    = wrapped[ADDR_W-1:0];

endmodule

// File: rtl/ifmap_window_reader.sv
// ifmap_window_reader: consumer side of the IFMap circular buffer.
// Walks a sliding window (filter_size taps, stride step) across each resident
// row and issues one buffer read per accepted cycle. It hands each consumed
// row back to the write side with end_row/next_row.
//   clk, rst         clock; asynchronous active-high reset
//   start            latch filter_size/stride/row_len/num_rows while IDLE
//   row_valid        a full row is resident; sampled in WAIT_ROW only
//   start_row_ptr    buffer address of element 0 of the row; sampled in LATCH
//   pe_ready         downstream accepts a read this cycle
//   rd_en, rd_addr   registered buffer read strobe and address
//   window_done      accompanies the last tap read of every window
//   end_row/next_row coincident pulses after the last read of a row
//   done             pulse after the last row (or right after start if num_rows==0)
//   cfg_err          pulse for a start with filter_size==0
//   busy             FSM is not IDLE
module ifmap_window_reader
  import ifmap_rd_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int BUF_DEPTH = BUF_DEPTH_DEF,
  parameter int FS_W      = FS_W_DEF,
  parameter int STRIDE_W  = STRIDE_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [FS_W-1:0]     filter_size,
  input  logic [STRIDE_W-1:0] stride,
  input  logic [ADDR_W-1:0]   row_len,
  input  logic [ADDR_W-1:0]   num_rows,
  input  logic                row_valid,
  input  logic [ADDR_W-1:0]   start_row_ptr,
  input  logic                pe_ready,
  output logic                rd_en,
  output logic [ADDR_W-1:0]   rd_addr,
  output logic                window_done,
  output logic                end_row,
  output logic                next_row,
  output logic                done,
  output logic                cfg_err,
  output logic                busy
);

  // Wide enough that window-end and row-count comparisons never overflow.
  localparam int CW = ADDR_W + FS_W + 2;

  state_t                state;
  logic [FS_W-1:0]       fs_r;
  logic [STRIDE_W-1:0]   stride_r;
  logic [ADDR_W-1:0]     row_len_r;
  logic [ADDR_W-1:0]     num_rows_r;
  logic [ADDR_W-1:0]     base_r;
  logic [ADDR_W-1:0]     win_base_r;
  logic [ADDR_W-1:0]     rows_cnt_r;
  logic [FS_W-1:0]       tap_r;

  logic [ADDR_W-1:0]     offset;
  logic [ADDR_W-1:0]     addr_nxt;
  logic [CW-1:0]         next_win_end;
  logic                  last_tap;
  logic                  more_win;
  logic                  too_wide;
  logic                  last_row;

  assign offset       = win_base_r + ADDR_W'(tap_r);
  assign last_tap     = (tap_r == fs_r - FS_W'(1));
  // The following window fits iff it ends at or before row_len.
  assign next_win_end = CW'(win_base_r) + CW'(stride_r) + CW'(fs_r);
  assign more_win     = (next_win_end <= CW'(row_len_r));
  assign too_wide     = (CW'(fs_r) > CW'(row_len_r));
  assign last_row     = ((CW'(rows_cnt_r) + CW'(1)) == CW'(num_rows_r));
  assign busy         = (state != IDLE);

  circ_addr_gen #(
    .ADDR_W   (ADDR_W),
    .BUF_DEPTH(BUF_DEPTH)
  ) u_addr_gen (
    .base  (base_r),
    .offset(offset),
    .addr  (addr_nxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      fs_r        <= '0;
      stride_r    <= '0;
      row_len_r   <= '0;
      num_rows_r  <= '0;
      base_r      <= '0;
      win_base_r  <= '0;
      rows_cnt_r  <= '0;
      tap_r       <= '0;
      rd_en       <= 1'b0;
      rd_addr     <= '0;
      window_done <= 1'b0;
      end_row     <= 1'b0;
      next_row    <= 1'b0;
      done        <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      // Strobes and pulses default low. rd_addr holds between reads.
      rd_en       <= 1'b0;
      window_done <= 1'b0;
      end_row     <= 1'b0;
      next_row    <= 1'b0;
      done        <= 1'b0;
      cfg_err     <= 1'b0;

      unique case (state)
        IDLE: begin
          if (start) begin
            if (filter_size == '0) begin
              cfg_err <= 1'b1;
            end else begin
              fs_r       <= filter_size;
              stride_r   <= (stride == '0) ? STRIDE_W'(1) : stride;
              row_len_r  <= row_len;
              num_rows_r <= num_rows;
              rows_cnt_r <= '0;
              // With no rows to process, the job is finished at once.
              if (num_rows == '0) done  <= 1'b1;
              else                state <= WAIT_ROW;
            end
          end
        end

        WAIT_ROW: begin
          if (row_valid) state <= LATCH;
        end

        LATCH: begin
          base_r     <= start_row_ptr;
          win_base_r <= '0;
          tap_r      <= '0;
          // A filter wider than the row yields zero windows.
          state      <= too_wide ? ROW_DONE : READ;
        end

        READ: begin
          if (pe_ready) begin
            rd_en   <= 1'b1;
            rd_addr <= addr_nxt;
            if (last_tap) begin
              window_done <= 1'b1;
              tap_r       <= '0;
              if (more_win) win_base_r <= win_base_r + ADDR_W'(stride_r);
              else          state      <= ROW_DONE;
            end else begin
              tap_r <= tap_r + FS_W'(1);
            end
          end
        end

        ROW_DONE: begin
          end_row    <= 1'b1;
          next_row   <= 1'b1;
          rows_cnt_r <= rows_cnt_r + ADDR_W'(1);
          if (last_row) begin
            done  <= 1'b1;
            state <= IDLE;
          end else begin
            state <= WAIT_ROW;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ifmap_window_reader.sv
module tb_ifmap_window_reader;
  localparam int ADDR_W    = 8;
  localparam int BUF_DEPTH = 16;
  localparam int FS_W      = 5;
  localparam int STRIDE_W  = 3;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                start = 1'b0;
  logic [FS_W-1:0]     filter_size = '0;
  logic [STRIDE_W-1:0] stride = '0;
  logic [ADDR_W-1:0]   row_len = '0;
  logic [ADDR_W-1:0]   num_rows = '0;
  logic                row_valid = 1'b0;
  logic [ADDR_W-1:0]   start_row_ptr = '0;
  logic                pe_ready = 1'b0;
  logic                rd_en;
  logic [ADDR_W-1:0]   rd_addr;
  logic                window_done;
  logic                end_row;
  logic                next_row;
  logic                done;
  logic                cfg_err;
  logic                busy;

  always #5 clk = ~clk;

  ifmap_window_reader #(
    .ADDR_W(ADDR_W), .BUF_DEPTH(BUF_DEPTH), .FS_W(FS_W), .STRIDE_W(STRIDE_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .filter_size(filter_size),
    .stride(stride), .row_len(row_len), .num_rows(num_rows),
    .row_valid(row_valid), .start_row_ptr(start_row_ptr), .pe_ready(pe_ready),
    .rd_en(rd_en), .rd_addr(rd_addr), .window_done(window_done),
    .end_row(end_row), .next_row(next_row), .done(done), .cfg_err(cfg_err),
    .busy(busy)
  );

  int errors = 0;
  int checks = 0;

  // Reference model output and observed trace.
  int exp_addr[$];
  bit exp_wd[$];
  int obs_addr[$];
  bit obs_wd[$];
  int lat_q[$];
  int gap_q[$];
  int stall_addr[$];
  int cur_ptrs[$];
  int er_cnt, done_cnt, done_cyc, last_er;
  int pulse_mis, wd_orphan, stall_viol, timeout, busy_after;
  logic [7:0] snap;

  // Windows start at 0, s, 2s, ... while the window still fits in the row;
  // each window reads fs consecutive elements, modulo the buffer depth.
  function automatic void build_model(input int fs, input int st, input int len, input int nr);
    int s;
    exp_addr.delete();
    exp_wd.delete();
    s = (st == 0) ? 1 : st;
    for (int r = 0; r < nr; r++) begin
      for (int w = 0; w + fs <= len; w += s) begin
        for (int t = 0; t < fs; t++) begin
          exp_addr.push_back((cur_ptrs[r] + w + t) % BUF_DEPTH);
          exp_wd.push_back(t == fs - 1);
        end
      end
    end
  endfunction

  function automatic int count_wd();
    int n = 0;
    foreach (obs_wd[i]) n += int'(obs_wd[i]);
    return n;
  endfunction

  // Drives one job and records what the DUT does. mode: 0 = pe_ready always 1,
  // 1 = random stalls / row_valid drops / stray starts, 2 = 3-cycle stall after
  // the 2nd read. abort_after > 0 asserts rst mid-cycle after that many reads.
  task automatic run_job(input int fs, input int st, input int len, input int nr,
                         input int mode, input int abort_after);
    int row_idx, dly, rv_cyc, last_rd, stall_left, post;
    bit row_active, row_has_rd, fin, stalled;
    logic [ADDR_W-1:0] prev_addr;
    obs_addr.delete(); obs_wd.delete(); lat_q.delete(); gap_q.delete(); stall_addr.delete();
    er_cnt = 0; done_cnt = 0; done_cyc = -1; last_er = -1;
    pulse_mis = 0; wd_orphan = 0; stall_viol = 0; timeout = 0; busy_after = 0;
    row_idx = 0; dly = $urandom_range(0, 2); rv_cyc = 0; last_rd = 0;
    stall_left = 0; post = 0; row_active = 0; row_has_rd = 0; fin = 0;
    for (int c = 0; c < 3000 && post < 3; c++) begin
      @(negedge clk);
      start = (c == 0) || (mode == 1 && !fin && $urandom_range(0, 9) == 0);
      if (c == 0) begin
        filter_size = FS_W'(fs); stride = STRIDE_W'(st);
        row_len = ADDR_W'(len); num_rows = ADDR_W'(nr);
      end else begin
        filter_size = FS_W'($urandom); stride = STRIDE_W'($urandom);
        row_len = ADDR_W'($urandom); num_rows = ADDR_W'($urandom);
      end
      if (row_active) begin
        row_valid = (row_has_rd && mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      end else if (c > 0 && row_idx < nr && !fin) begin
        if (dly > 0) begin
          dly--; row_valid = 1'b0;
        end else begin
          row_valid = 1'b1; row_active = 1; rv_cyc = c;
          start_row_ptr = ADDR_W'(cur_ptrs[row_idx]);
        end
      end else begin
        row_valid = 1'b0;
      end
      if (mode == 1) pe_ready = ($urandom_range(0, 99) >= 30);
      else if (stall_left > 0) begin pe_ready = 1'b0; stall_left--; end
      else pe_ready = 1'b1;
      stalled = !pe_ready;
      prev_addr = rd_addr;
      @(posedge clk); #1;
      if (stalled && (rd_en !== 1'b0 || rd_addr !== prev_addr)) stall_viol++;
      if (stalled && mode == 2) stall_addr.push_back(int'(rd_addr));
      if (rd_en === 1'b1) begin
        if (!row_has_rd) lat_q.push_back(c - rv_cyc);
        row_has_rd = 1; last_rd = c;
        obs_addr.push_back(int'(rd_addr));
        obs_wd.push_back(window_done === 1'b1);
        if (mode == 2 && obs_addr.size() == 2) stall_left = 3;
        if (abort_after > 0 && obs_addr.size() == abort_after) begin
          #2 rst = 1'b1;
          #1 snap = {rd_en, |rd_addr, window_done, end_row, next_row, done, cfg_err, busy};
          return;
        end
      end else if (window_done !== 1'b0) begin
        wd_orphan++;
      end
      if (next_row !== end_row) pulse_mis++;
      if (end_row === 1'b1) begin
        gap_q.push_back(c - (row_has_rd ? last_rd : rv_cyc));
        er_cnt++; last_er = c; row_active = 0; row_has_rd = 0; row_idx++;
        dly = $urandom_range(0, 2);
      end
      if (done === 1'b1) begin done_cnt++; done_cyc = c; fin = 1; end
      if (fin) begin
        post++;
        if (busy !== 1'b0) busy_after++;
      end
    end
    start = 1'b0; row_valid = 1'b0;
    if (!fin) timeout = 1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({rd_en, window_done, end_row, next_row, done, cfg_err, busy} !== 7'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 0000000",
               {rd_en, window_done, end_row, next_row, done, cfg_err, busy});
    end
    checks++;
    if (rd_addr !== '0) begin
      errors++; $display("FAIL reset_rd_addr: got %0d expected 0", rd_addr);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_row();
    cur_ptrs = '{0};
    run_job(3, 1, 8, 1, 0, 0);
    build_model(3, 1, 8, 1);
    checks++;
    if (timeout != 0) begin errors++; $display("FAIL basic_timeout: done never seen within budget"); end
    checks++;
    if (obs_addr.size() != 18) begin errors++; $display("FAIL basic_reads: got %0d expected 18", obs_addr.size()); end
    for (int i = 0; i < obs_addr.size() && i < exp_addr.size(); i++) begin
      checks++;
      if (obs_addr[i] != exp_addr[i] || obs_wd[i] != exp_wd[i]) begin
        errors++;
        $display("FAIL basic_read[%0d]: got addr %0d wd %0d expected addr %0d wd %0d",
                 i, obs_addr[i], obs_wd[i], exp_addr[i], exp_wd[i]);
      end
    end
    checks++;
    if (count_wd() != 6 || wd_orphan != 0) begin
      errors++; $display("FAIL basic_windows: got %0d (orphans %0d) expected 6 (0)", count_wd(), wd_orphan);
    end
    checks++;
    if (lat_q.size() != 1 || lat_q[0] != 2) begin
      errors++; $display("FAIL basic_latency: got %0d expected 2", (lat_q.size() > 0) ? lat_q[0] : -1);
    end
    checks++;
    if (er_cnt != 1 || gap_q[0] != 1 || pulse_mis != 0) begin
      errors++; $display("FAIL basic_end_row: got count %0d gap %0d mis %0d expected 1 1 0",
                         er_cnt, (gap_q.size() > 0) ? gap_q[0] : -1, pulse_mis);
    end
    checks++;
    if (done_cnt != 1 || done_cyc != last_er || busy_after != 0) begin
      errors++; $display("FAIL basic_done: got count %0d cyc %0d busy_after %0d expected 1 %0d 0",
                         done_cnt, done_cyc, busy_after, last_er);
    end
  endtask

  task automatic test_stride_wrap();
    int want[$];
    want = '{4, 5, 6, 6, 7, 8, 8, 9, 10, 12, 13, 14, 14, 15, 0, 0, 1, 2};
    cur_ptrs = '{4, 12};
    run_job(3, 2, 8, 2, 0, 0);
    checks++;
    if (obs_addr.size() != want.size() || timeout != 0) begin
      errors++; $display("FAIL wrap_reads: got %0d (timeout %0d) expected %0d", obs_addr.size(), timeout, want.size());
    end
    for (int i = 0; i < obs_addr.size() && i < want.size(); i++) begin
      checks++;
      if (obs_addr[i] != want[i]) begin
        errors++; $display("FAIL wrap_addr[%0d]: got %0d expected %0d", i, obs_addr[i], want[i]);
      end
    end
    checks++;
    if (er_cnt != 2 || pulse_mis != 0 || gap_q.size() != 2 || gap_q[0] != 1 || gap_q[1] != 1) begin
      errors++; $display("FAIL wrap_end_row: got count %0d mis %0d expected 2 0", er_cnt, pulse_mis);
    end
    checks++;
    if (done_cnt != 1 || done_cyc != last_er) begin
      errors++; $display("FAIL wrap_done: got count %0d cyc %0d expected 1 %0d", done_cnt, done_cyc, last_er);
    end
  endtask

  task automatic test_stall();
    cur_ptrs = '{0};
    run_job(3, 1, 8, 1, 2, 0);
    build_model(3, 1, 8, 1);
    checks++;
    if (stall_addr.size() != 3 || stall_viol != 0) begin
      errors++; $display("FAIL stall_hold: got %0d stalled cycles, %0d violations expected 3, 0",
                         stall_addr.size(), stall_viol);
    end
    foreach (stall_addr[i]) begin
      checks++;
      if (stall_addr[i] != 1) begin
        errors++; $display("FAIL stall_addr[%0d]: got %0d expected 1", i, stall_addr[i]);
      end
    end
    checks++;
    if (obs_addr.size() != 18 || timeout != 0) begin
      errors++; $display("FAIL stall_reads: got %0d expected 18", obs_addr.size());
    end
    for (int i = 0; i < obs_addr.size() && i < exp_addr.size(); i++) begin
      checks++;
      if (obs_addr[i] != exp_addr[i] || obs_wd[i] != exp_wd[i]) begin
        errors++; $display("FAIL stall_read[%0d]: got addr %0d expected %0d", i, obs_addr[i], exp_addr[i]);
      end
    end
  endtask

  task automatic test_fs_gt_row();
    cur_ptrs = '{3};
    run_job(10, 1, 8, 1, 0, 0);
    checks++;
    if (obs_addr.size() != 0) begin
      errors++; $display("FAIL wide_reads: got %0d expected 0", obs_addr.size());
    end
    checks++;
    if (er_cnt != 1 || gap_q.size() != 1 || gap_q[0] != 2 || pulse_mis != 0) begin
      errors++; $display("FAIL wide_end_row: got count %0d gap %0d expected 1 2",
                         er_cnt, (gap_q.size() > 0) ? gap_q[0] : -1);
    end
    checks++;
    if (done_cnt != 1 || done_cyc != last_er || timeout != 0) begin
      errors++; $display("FAIL wide_done: got cyc %0d expected %0d", done_cyc, last_er);
    end
  endtask

  task automatic test_cfg_err();
    int n_err, n_busy, n_rd;
    n_err = 0; n_busy = 0; n_rd = 0;
    @(negedge clk);
    filter_size = '0; stride = 3'd1; row_len = 8'd8; num_rows = 8'd1;
    row_valid = 1'b1; pe_ready = 1'b1; start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_err += int'(cfg_err); n_busy += int'(busy); n_rd += int'(rd_en);
      @(negedge clk);
      start = 1'b0;
    end
    row_valid = 1'b0;
    checks++;
    if (n_err != 1) begin errors++; $display("FAIL cfg_err_pulse: got %0d cycles expected 1", n_err); end
    checks++;
    if (n_busy != 0 || n_rd != 0) begin
      errors++; $display("FAIL cfg_err_idle: got busy %0d reads %0d expected 0 0", n_busy, n_rd);
    end
    // stride 0 acts as stride 1
    cur_ptrs = '{5};
    run_job(2, 0, 4, 1, 0, 0);
    build_model(2, 0, 4, 1);
    checks++;
    if (count_wd() != 3 || obs_addr.size() != 6) begin
      errors++; $display("FAIL stride0_windows: got %0d windows %0d reads expected 3 6", count_wd(), obs_addr.size());
    end
    for (int i = 0; i < obs_addr.size() && i < exp_addr.size(); i++) begin
      checks++;
      if (obs_addr[i] != exp_addr[i]) begin
        errors++; $display("FAIL stride0_addr[%0d]: got %0d expected %0d", i, obs_addr[i], exp_addr[i]);
      end
    end
    // zero rows: done right after start, nothing else
    run_job(3, 1, 8, 0, 0, 0);
    checks++;
    if (done_cyc != 0 || done_cnt != 1 || obs_addr.size() != 0 || er_cnt != 0) begin
      errors++; $display("FAIL zero_rows: got done cyc %0d count %0d reads %0d rows %0d expected 0 1 0 0",
                         done_cyc, done_cnt, obs_addr.size(), er_cnt);
    end
  endtask

  task automatic test_reset_mid();
    cur_ptrs = '{0};
    run_job(3, 1, 8, 1, 0, 7);
    checks++;
    if (snap !== 8'h00) begin
      errors++; $display("FAIL reset_mid_outputs: got %b expected 00000000", snap);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    run_job(3, 1, 8, 1, 0, 0);
    build_model(3, 1, 8, 1);
    checks++;
    if (obs_addr.size() != exp_addr.size() || done_cnt != 1 || er_cnt != 1 || timeout != 0) begin
      errors++; $display("FAIL reset_mid_rerun: got %0d reads %0d done expected %0d 1",
                         obs_addr.size(), done_cnt, exp_addr.size());
    end
    for (int i = 0; i < obs_addr.size() && i < exp_addr.size(); i++) begin
      checks++;
      if (obs_addr[i] != exp_addr[i] || obs_wd[i] != exp_wd[i]) begin
        errors++; $display("FAIL reset_mid_read[%0d]: got %0d expected %0d", i, obs_addr[i], exp_addr[i]);
      end
    end
  endtask

  task automatic test_random();
    int fs, st, len, nr, bad, exp_gap;
    for (int j = 0; j < 12; j++) begin
      fs = $urandom_range(1, 6); st = $urandom_range(0, 7);
      len = $urandom_range(1, BUF_DEPTH); nr = $urandom_range(0, 3);
      cur_ptrs.delete();
      for (int r = 0; r < nr; r++) cur_ptrs.push_back($urandom_range(0, BUF_DEPTH - 1));
      run_job(fs, st, len, nr, 1, 0);
      build_model(fs, st, len, nr);
      checks++;
      if (obs_addr.size() != exp_addr.size() || timeout != 0) begin
        errors++; $display("FAIL rand%0d_reads: got %0d (timeout %0d) expected %0d fs=%0d st=%0d len=%0d nr=%0d",
                           j, obs_addr.size(), timeout, exp_addr.size(), fs, st, len, nr);
      end
      bad = 0;
      for (int i = 0; i < obs_addr.size() && i < exp_addr.size(); i++)
        if (obs_addr[i] != exp_addr[i] || obs_wd[i] != exp_wd[i]) bad++;
      checks++;
      if (bad != 0) begin
        errors++; $display("FAIL rand%0d_sequence: got %0d wrong reads expected 0", j, bad);
      end
      exp_gap = (fs <= len) ? 1 : 2;
      bad = 0;
      foreach (gap_q[i]) if (gap_q[i] != exp_gap) bad++;
      checks++;
      if (er_cnt != nr || bad != 0 || pulse_mis != 0) begin
        errors++; $display("FAIL rand%0d_rows: got %0d rows %0d bad gaps %0d mis expected %0d 0 0",
                           j, er_cnt, bad, pulse_mis, nr);
      end
      checks++;
      if (done_cnt != 1 || stall_viol != 0 || wd_orphan != 0 || busy_after != 0) begin
        errors++; $display("FAIL rand%0d_ctrl: got done %0d stall_viol %0d orphans %0d busy_after %0d expected 1 0 0 0",
                           j, done_cnt, stall_viol, wd_orphan, busy_after);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_row();
    test_stride_wrap();
    test_stall();
    test_fs_gt_row();
    test_cfg_err();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
